// File: rtl/axis_tile_source_pkg.sv
// -----------------------------------------------------------------------------
// axis_tile_source_pkg
//
// Shared types and constants for the tile stream source.
//   tile_state_t : playback FSM state (IDLE, SEND, GAP, DONE)
//   BEAT_WIDTH   : default beat width (elements per beat * bits per element)
//   STALL_WIDTH  : width of the backpressure cycle counter
//   GAP_WIDTH    : width of the inter-beat idle cycle count
//
// The GAP state only does work when THROTTLE_EN is defined; the encoding is
// kept in every build so debug tooling sees one stable enum.
// -----------------------------------------------------------------------------
package axis_tile_source_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } tile_state_t;

    localparam int DEFAULT_N          = 4;
    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int BEAT_WIDTH         = DEFAULT_N * DEFAULT_DATA_WIDTH;
    localparam int STALL_WIDTH        = 32;
    localparam int GAP_WIDTH          = 4;

endpackage

// File: rtl/axis_tile_source_if.sv
// -----------------------------------------------------------------------------
// axis_tile_source_if
//
// AXI4-Stream link carrying one tile column per beat.
//   tdata  : beat payload (WIDTH bits)
//   tvalid : master has a beat
//   tready : slave accepts the beat
//   tlast  : final beat of a playback
//
// Handshake: a beat transfers on a rising edge where tvalid && tready. Once
// tvalid is high it stays high, with tdata/tlast stable, until that transfer;
// tvalid never depends combinationally on tready.
//
// Modports: master (source side), slave (sink side).
// -----------------------------------------------------------------------------
interface axis_tile_source_if #(
    parameter int WIDTH = axis_tile_source_pkg::BEAT_WIDTH
) ();
    logic [WIDTH-1:0] tdata;
    logic             tvalid;
    logic             tready;
    logic             tlast;

    modport master (output tdata, output tvalid, output tlast, input  tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/axis_tile_source_buffer.sv
// -----------------------------------------------------------------------------
// tile_beat_buffer
//
// DEPTH x WIDTH register array holding the tile to be played back.
//   clk     : write clock
//   wr_en   : write strobe (already qualified by the caller)
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : read address
//   rd_data : combinational read data
//
// Contents are deliberately not reset.
// -----------------------------------------------------------------------------
module tile_beat_buffer
    import axis_tile_source_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = BEAT_WIDTH
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/axis_tile_source.sv
// -----------------------------------------------------------------------------
// axis_tile_source
//
// AXI4-Stream master that plays back a preloaded tile, one N-element column
// per beat, with tlast on the final beat, and counts backpressure cycles.
//
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   wr_en/addr/data : tile buffer write port (ignored while busy)
//   start        : playback request pulse (ignored while busy)
//   beats        : beats to send, sampled on an accepted start, clamped to DEPTH
//   gap          : idle cycles after each non-final beat (THROTTLE_EN only)
//   busy         : high in SEND, GAP and DONE
//   done         : one-cycle pulse after the final beat is accepted
//   stall_count  : SEND cycles with tready low, saturating, cleared on start
//   state_dbg    : current FSM state
//   axis         : stream master port
//
// Build option: define THROTTLE_EN to add the gap port and the GAP state.
// Without it, beats are always back-to-back when tready allows.
//
// All stream outputs are registered, so tvalid has no combinational path
// from tready.
// -----------------------------------------------------------------------------
module axis_tile_source
    import axis_tile_source_pkg::*;
#(
    parameter int N          = DEFAULT_N,
    parameter int data_width = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [N*data_width-1:0]    wr_data,
    input  logic                       start,
    input  logic [$clog2(DEPTH):0]     beats,
`ifdef THROTTLE_EN
    input  logic [GAP_WIDTH-1:0]       gap,
`endif
    output logic                       busy,
    output logic                       done,
    output logic [STALL_WIDTH-1:0]     stall_count,
    output tile_state_t                state_dbg,
    axis_tile_source_if.master         axis
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = N * data_width;

    tile_state_t    state;
    logic [AW-1:0]  idx;        // index of the beat currently presented
    logic [CW-1:0]  beats_q;    // latched, clamped beat count
    logic [BW-1:0]  tdata_q;
    logic           tvalid_q;
    logic           tlast_q;
`ifdef THROTTLE_EN
    logic [GAP_WIDTH-1:0] gap_cnt;
`endif

    logic [AW-1:0]  rd_addr;
    logic [BW-1:0]  rd_data;
    logic [CW-1:0]  beats_req;
    logic           next_is_last;   // beat idx+1 is the final one
    logic           cur_is_last;    // beat idx is the final one

    assign beats_req    = (beats > CW'(DEPTH)) ? CW'(DEPTH) : beats;
    assign next_is_last = (({1'b0, idx} + CW'(2)) == beats_q);
    assign cur_is_last  = (({1'b0, idx} + CW'(1)) == beats_q);

    // Read address points at the beat that will be loaded on the next edge:
    // beat 0 from IDLE, idx+1 for back-to-back in SEND, idx (already
    // advanced) when leaving GAP.
    always_comb begin
        rd_addr = '0;
        case (state)
            ST_SEND: rd_addr = idx + AW'(1);
            ST_GAP:  rd_addr = idx;
            default: rd_addr = '0;
        endcase
    end

    tile_beat_buffer #(
        .DEPTH (DEPTH),
        .WIDTH (BW)
    ) u_buffer (
        .clk     (clk),
        .wr_en   (wr_en && !busy),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            idx         <= '0;
            beats_q     <= '0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            stall_count <= '0;
`ifdef THROTTLE_EN
            gap_cnt     <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy        <= 1'b1;
                        stall_count <= '0;
                        if (beats_req == '0) begin
                            // Nothing to send: acknowledge with a done pulse only.
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            beats_q  <= beats_req;
                            idx      <= '0;
                            tdata_q  <= rd_data;
                            tvalid_q <= 1'b1;
                            tlast_q  <= (beats_req == CW'(1));
                            state    <= ST_SEND;
                        end
                    end
                end

                ST_SEND: begin
                    if (!axis.tready) begin
                        if (stall_count != '1) begin
                            stall_count <= stall_count + 1'b1;
                        end
                    end else if (tlast_q) begin
                        tvalid_q <= 1'b0;
                        tlast_q  <= 1'b0;
                        done     <= 1'b1;
                        state    <= ST_DONE;
                    end
`ifdef THROTTLE_EN
                    else if (gap != '0) begin
                        idx      <= idx + AW'(1);
                        gap_cnt  <= gap;
                        tvalid_q <= 1'b0;
                        tlast_q  <= 1'b0;
                        state    <= ST_GAP;
                    end
`endif
                    else begin
                        idx     <= idx + AW'(1);
                        tdata_q <= rd_data;
                        tlast_q <= next_is_last;
                    end
                end

                ST_GAP: begin
`ifdef THROTTLE_EN
                    // gap_cnt holds the idle cycles still to run, including this one.
                    if (gap_cnt == GAP_WIDTH'(1)) begin
                        tdata_q  <= rd_data;
                        tvalid_q <= 1'b1;
                        tlast_q  <= cur_is_last;
                        state    <= ST_SEND;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_WIDTH'(1);
                    end
`else
                    // Unreachable without throttling; recover to idle.
                    busy  <= 1'b0;
                    state <= ST_IDLE;
`endif
                end

                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign axis.tdata  = tdata_q;
    assign axis.tvalid = tvalid_q;
    assign axis.tlast  = tlast_q;
    assign state_dbg   = state;

endmodule

// File: tb/tb_axis_tile_source.sv
// -----------------------------------------------------------------------------
// tb_axis_tile_source
//
// Self-checking bench for axis_tile_source. A playback is modelled as a queue
// of expected beats (the first min(beats, DEPTH) buffer words); the stream
// presents the queue head whenever it is not sitting out an inter-beat gap,
// pops it on each accepted transfer, and counts cycles where a beat was
// offered but not taken. Inputs change on the falling edge, outputs are
// sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_axis_tile_source;
    import axis_tile_source_pkg::*;

    localparam int N      = 4;
    localparam int DW     = 8;
    localparam int DEPTH  = 16;
    localparam int BW     = N * DW;
    localparam int AW     = $clog2(DEPTH);
    localparam int CW     = AW + 1;
    localparam int BUDGET = 2000;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [BW-1:0] wr_data;
    logic          start;
    logic [CW-1:0] beats;
    logic [3:0]    gap;
    logic          busy;
    logic          done;
    logic [31:0]   stall_count;
    tile_state_t   state_dbg;

    axis_tile_source_if #(.WIDTH(BW)) axis ();

    axis_tile_source #(
        .N          (N),
        .data_width (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .start       (start),
        .beats       (beats),
`ifdef THROTTLE_EN
        .gap         (gap),
`endif
        .busy        (busy),
        .done        (done),
        .stall_count (stall_count),
        .state_dbg   (state_dbg),
        .axis        (axis)
    );

    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int            n_tests = 0;
    int            n_fail  = 0;
    logic [BW-1:0] mem_model [DEPTH];
    logic [BW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int gap_eff(input logic [3:0] g);
`ifdef THROTTLE_EN
        return int'(g);
`else
        return 0;
`endif
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        reset       = 1'b1;
        start       = 1'b0;
        wr_en       = 1'b0;
        axis.tready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic write_word(input int addr, input logic [BW-1:0] data);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_data = data;
        @(negedge clk);
        wr_en = 1'b0;
        mem_model[addr] = data;
    endtask

    // Starts a playback at the current falling edge and follows it to idle.
    // stall_pos/stall_len force tready low for stall_len cycles while beat
    // stall_pos is offered; noise adds ignored starts and writes.
    task automatic run_playback(input int req_beats, input logic [3:0] g, input int ready_pct,
                                input int stall_pos, input int stall_len, input bit noise);
        int n;
        int pos;
        int gap_left;
        int stalled;
        int stall_exp;
        int cyc;
        bit finished;
        bit valid_exp;
        bit rdy;
        n         = (req_beats > DEPTH) ? DEPTH : req_beats;
        pos       = 0;
        gap_left  = 0;
        stalled   = 0;
        stall_exp = 0;
        cyc       = 0;
        finished  = (n == 0);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(mem_model[i]);

        beats = CW'(req_beats);
        gap   = g;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        while (!finished && cyc < BUDGET) begin
            valid_exp = (gap_left == 0);
            check("tvalid", axis.tvalid, valid_exp);
            check("busy_run", busy, 1'b1);
            check("done_run", done, 1'b0);
            if (valid_exp) begin
                check("tdata", axis.tdata, exp_q[0]);
                check("tlast", axis.tlast, exp_q.size() == 1);
            end

            start = 1'b0;
            wr_en = 1'b0;
            if (valid_exp && pos == stall_pos && stalled < stall_len) begin
                rdy = 1'b0;
                stalled++;
            end else begin
                rdy = ($urandom_range(0, 99) < ready_pct);
            end
            axis.tready = rdy;
            if (noise && $urandom_range(0, 3) == 0) begin
                start = 1'b1;
                beats = CW'($urandom_range(1, 16));
            end
            if (noise && $urandom_range(0, 3) == 0) begin
                wr_en   = 1'b1;
                wr_addr = AW'($urandom_range(0, DEPTH - 1));
                wr_data = $urandom;
            end

            if (valid_exp) begin
                if (rdy) begin
                    void'(exp_q.pop_front());
                    pos++;
                    if (exp_q.size() == 0) finished = 1'b1;
                    else gap_left = gap_eff(gap);
                end else begin
                    stall_exp++;
                end
            end else begin
                gap_left--;
            end
            @(negedge clk);
            cyc++;
        end
        if (!finished) check("playback_timeout", 1'b1, 1'b0);

        // DONE cycle
        check("done_pulse", done, 1'b1);
        check("busy_done", busy, 1'b1);
        check("tvalid_done", axis.tvalid, 1'b0);
        check("stall_count", stall_count, 64'(stall_exp));
        start       = 1'b0;
        wr_en       = 1'b0;
        axis.tready = ($urandom_range(0, 1) == 1);
        @(negedge clk);
        // Back in idle
        check("done_clear", done, 1'b0);
        check("busy_idle", busy, 1'b0);
        check("tvalid_idle", axis.tvalid, 1'b0);
        check("stall_hold", stall_count, 64'(stall_exp));
    endtask

    task automatic run_reset_abort();
        beats       = CW'(8);
        gap         = 4'd0;
        start       = 1'b1;
        axis.tready = 1'b0;
        @(negedge clk);
        start       = 1'b0;
        axis.tready = 1'b0;   // beat 0 refused once
        @(negedge clk);
        axis.tready = 1'b1;   // beats 0 and 1 accepted
        @(negedge clk);
        @(negedge clk);
        check("abort_beat2", axis.tdata, mem_model[2]);
        check("abort_stall_pre", stall_count, 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_tvalid", axis.tvalid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_stall", stall_count, 64'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_done", done, 1'b0);
            check("abort_quiet", axis.tvalid, 1'b0);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        start       = 1'b0;
        beats       = '0;
        gap         = '0;
        axis.tready = 1'b0;
        do_reset();

        check("rst_tvalid", axis.tvalid, 1'b0);
        check("rst_tlast", axis.tlast, 1'b0);
        check("rst_tdata", axis.tdata, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_stall", stall_count, '0);
        check("rst_state", state_dbg, ST_IDLE);

        // Basic 4-beat tile, free-flowing
        write_word(0, 32'h04030201);
        write_word(1, 32'h08070605);
        write_word(2, 32'h0C0B0A09);
        write_word(3, 32'h100F0E0D);
        run_playback(4, 4'd0, 100, -1, 0, 1'b0);

        // Three-cycle stall on beat 2
        run_playback(4, 4'd0, 100, 2, 3, 1'b0);

        // Empty playback
        run_playback(0, 4'd0, 100, -1, 0, 1'b0);

        // Full buffer, single beat, then full length with ignored starts/writes
        for (int i = 0; i < DEPTH; i++) write_word(i, $urandom);
        run_playback(1, 4'd0, 100, -1, 0, 1'b0);
        run_playback(16, 4'd0, 100, -1, 0, 1'b1);

        // Reset mid-transfer, then replay from the start
        run_reset_abort();
        run_playback(8, 4'd0, 100, -1, 0, 1'b0);

        // Gap of 2 on a 3-beat run with writes during the run, then replay
        run_playback(3, 4'd2, 100, -1, 0, 1'b1);
        run_playback(3, 4'd0, 100, -1, 0, 1'b0);

        // Beat count above DEPTH is clamped
        run_playback(20, 4'd0, 80, -1, 0, 1'b0);

        // Randomized runs
        for (int r = 0; r < 10; r++) begin
            run_playback($urandom_range(0, 20), 4'($urandom_range(0, 3)),
                         $urandom_range(40, 100), $urandom_range(0, 5),
                         $urandom_range(0, 3), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_tile_source.md
# axis_tile_source

AXI4-Stream master that streams a preloaded matrix tile, one N-element column per beat, into the systolic array's stream input port. It is the transmitting end of the input-side stream link, used both as the on-chip feeder and as the bench traffic source. It holds up to DEPTH beats in a local buffer and plays back `beats` of them on `start`, with `tlast` on the final beat. It also counts backpressure cycles so array throughput can be measured.

## Interface
Parameters:
- N, 4, elements per beat (array width)
- data_width, 8, bits per element
- DEPTH, 16, beat buffer entries (power of two)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- wr_en  in  1  buffer write strobe
- wr_addr  in  $clog2(DEPTH)  buffer write address
- wr_data  in  N*data_width  buffer write data
- start  in  1  begin playback (single-cycle pulse)
- beats  in  $clog2(DEPTH)+1  number of beats to send, sampled on accepted start
- gap  in  4  idle cycles inserted after each beat (present only with THROTTLE_EN)
- busy  out  1  playback in progress
- done  out  1  one-cycle pulse after the last beat is accepted
- stall_count  out  32  cycles with tvalid=1, tready=0 in the current or most recent playback
- tdata  out  N*data_width  stream data
- tvalid  out  1  stream valid
- tready  in  1  stream ready from downstream
- tlast  out  1  final beat marker

## Operation
- FSM states: IDLE, SEND, GAP (THROTTLE_EN only), DONE.
- IDLE: `busy`=0. On `start` with `beats`≥1: latch `beats`, set idx=0, load tdata←buf[0], clear stall_count, go to SEND. On `start` with `beats`=0: go to DONE directly; no beat is sent.
- SEND: `tvalid`=1. `tlast`=1 when idx==beats_latched-1. On handshake (`tvalid`&&`tready`), the next state is chosen in this order:
  - if last: go to DONE;
  - else if THROTTLE_EN and `gap`≠0: idx++, go to GAP;
  - otherwise: idx++, tdata←buf[idx+1], stay in SEND (back-to-back beats).
- GAP: `tvalid`=0. Count `gap` cycles (`gap` sampled on entry), then load tdata←buf[idx] and return to SEND.
- DONE: `done`=1 for exactly one cycle, then return to IDLE.
- AXI rules:
  - `tdata` and `tlast` stay stable while `tvalid`=1 and `tready`=0.
  - `tvalid` never drops without a handshake.
  - `tvalid` never depends combinationally on `tready`.
- stall_count increments on each SEND cycle with `tready`=0 and saturates at 2^32-1. It holds its value after DONE until the next accepted start.
- Buffer writes are accepted only when `busy`=0. `wr_en` while busy is ignored.
- `start` while busy is ignored.
- `beats`>DEPTH is clamped to DEPTH.
- `busy`=1 in SEND, GAP and DONE.

## Timing
- Reset values: tvalid=0, tlast=0, tdata=0, busy=0, done=0, stall_count=0, state=IDLE, idx=0. Buffer contents are not reset.
- `start` is seen on edge k. At edge k, the FSM enters SEND; `tvalid`=1 and `tdata`=buf[0] during cycle k+1.
- With `tready` held at 1 and no gap: one beat per cycle. The last beat is accepted at edge k+beats, and `done`=1 during cycle k+beats+1.
- A write to address A at edge j is visible to a playback started at edge j+1 or later.
- Reset asserted mid-transfer: `tvalid` is 0 from the next edge. No `done` pulse is produced. stall_count clears.

## Configuration
- THROTTLE_EN defined: the `gap` port and the GAP state exist. After each non-final beat, `tvalid` drops for `gap` cycles. `gap`=0 gives back-to-back behaviour.
- THROTTLE_EN undefined: no `gap` port and no GAP state. Beats are always back-to-back when `tready` allows.

## Structure
- The shared package holds:
  - FSM state enum (IDLE, SEND, GAP, DONE);
  - beat width localparam N*data_width;
  - stall counter width 32.
- One sub-module, `tile_beat_buffer`: DEPTH×(N*data_width) register array with a synchronous write port and a combinational read port.

## Test plan
- Load buf[0..3]=0x04030201, 0x08070605, 0x0C0B0A09, 0x100F0E0D; start with beats=4 and tready=1. Required: 4 consecutive beats in order, tlast only on 0x100F0E0D, done pulse one cycle after, stall_count=0.
- Same tile with tready low for 3 cycles on beat 2. Required: tdata holds 0x0C0B0A09 and tvalid stays high through the stall; stall_count=3; every beat is delivered exactly once.
- start with beats=0. Required: no tvalid at any cycle; done pulses exactly once; busy is high for one cycle.
- beats=1. Required: a single beat with tlast=1. Then start again with beats=16. Required: tlast only on idx 15. A start issued mid-playback has no effect.
- Reset asserted at the 3rd beat of an 8-beat run. Required: tvalid=0 at the next edge, no done pulse, stall_count=0. A subsequent start replays from buf[0].
- THROTTLE_EN with gap=2 and beats=3. Required: tvalid pattern 1,0,0,1,0,0,1 and done pulses afterwards. wr_en during the run leaves the buffer unchanged.
